// File: rtl/dca_row_loader_pkg.sv
// Shared constants for the matrix row loader: instruction field layout and FSM encoding.
package dca_row_loader_pkg;
  localparam int BW_ROW_LOAD_INST = 80;
  localparam int BASE_LSB         = 0;
  localparam int STRIDE_LSB       = 32;
  localparam int NUM_ROW_LSB      = 64;
  localparam int BW_NUM_ROW       = 16;
  localparam int BW_INST_FIELD    = 32;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DECODE = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } state_t;
endpackage

// File: rtl/dca_row_loader_addrgen.sv
// Read-address generator: walks rows/beats with a row-base accumulator and beat adder.
module dca_row_loader_addrgen
  import dca_row_loader_pkg::*;
#(
  parameter int BW_ADDR       = 32,
  parameter int BW_DATA       = 64,
  parameter int BEATS_PER_ROW = 2
) (
  input  logic                  clk,
  input  logic                  rstp,
  input  logic                  clear,
  input  logic                  enable,
  input  logic                  allow,
  input  logic [BW_ADDR-1:0]    base,
  input  logic [BW_ADDR-1:0]    stride,
  input  logic [BW_NUM_ROW-1:0] num_row,
  output logic                  valid,
  input  logic                  ready,
  output logic [BW_ADDR-1:0]    addr
);
  localparam int                 BW_BEAT    = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [BW_BEAT-1:0] LAST_BEAT  = BW_BEAT'(BEATS_PER_ROW - 1);
  localparam logic [BW_ADDR-1:0] BEAT_BYTES = BW_ADDR'(BW_DATA / 8);

  logic [BW_NUM_ROW-1:0] row_cnt;
  logic [BW_BEAT-1:0]    beat_cnt;
  logic [BW_ADDR-1:0]    row_base;
  logic                  pending;
  logic                  fire;

  // valid only falls through allow, which cannot drop while a request is stalled
  assign valid = enable && pending && allow;
  assign fire  = valid && ready;

  always_ff @(posedge clk) begin
    if (rstp) begin
      row_cnt  <= '0;
      beat_cnt <= '0;
      row_base <= '0;
      addr     <= '0;
      pending  <= 1'b0;
    end else if (clear) begin
      row_cnt  <= '0;
      beat_cnt <= '0;
      row_base <= base;
      addr     <= base;
      pending  <= (num_row != '0);
    end else if (fire) begin
      if (beat_cnt == LAST_BEAT) begin
        beat_cnt <= '0;
        row_cnt  <= row_cnt + 1'b1;
        row_base <= row_base + stride;
        addr     <= row_base + stride;
        if (row_cnt == num_row - 1'b1) pending <= 1'b0;
      end else begin
        beat_cnt <= beat_cnt + 1'b1;
        addr     <= addr + BEAT_BYTES;
      end
    end
  end
endmodule

// File: rtl/dca_matrix_row_loader.sv
// Matrix-load row streamer: decodes one instruction, issues beat reads, assembles rows
// and hands them to the GEMM core with wlast on the final row.
module dca_matrix_row_loader
  import dca_row_loader_pkg::*;
#(
  parameter int BW_ADDR         = 32,
  parameter int BW_DATA         = 64,
  parameter int BEATS_PER_ROW   = 2,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                              clk,
  input  logic                              rstp,
  input  logic                              sinst_wvalid,
  input  logic [BW_ROW_LOAD_INST-1:0]       sinst_wdata,
  output logic                              sinst_wready,
  output logic                              sinst_decode_finish,
  output logic                              sinst_execute_finish,
  output logic                              sinst_busy,
  output logic                              rreq_valid,
  input  logic                              rreq_ready,
  output logic [BW_ADDR-1:0]                rreq_addr,
  input  logic                              rresp_valid,
  output logic                              rresp_ready,
  input  logic [BW_DATA-1:0]                rresp_data,
  output logic                              load_tensor_row_wvalid,
  input  logic                              load_tensor_row_wready,
  output logic                              load_tensor_row_wlast,
  output logic [BW_DATA*BEATS_PER_ROW-1:0]  load_tensor_row_wdata
);
  localparam int                 BW_ROW    = BW_DATA * BEATS_PER_ROW;
  localparam int                 BW_BEAT   = (BEATS_PER_ROW > 1) ? $clog2(BEATS_PER_ROW) : 1;
  localparam logic [BW_BEAT-1:0] LAST_BEAT = BW_BEAT'(BEATS_PER_ROW - 1);
  localparam int                 BW_OUT    = $clog2(MAX_OUTSTANDING) + 1;
  localparam logic [BW_OUT-1:0]  MAX_OUT   = BW_OUT'(MAX_OUTSTANDING);

  state_t                state;
  logic [BW_ADDR-1:0]    base_q;
  logic [BW_ADDR-1:0]    stride_q;
  logic [BW_NUM_ROW-1:0] num_row_q;
  logic [BW_NUM_ROW-1:0] rows_built;
  logic [BW_OUT-1:0]     outstanding;
  logic [BW_BEAT-1:0]    rsp_beat;
  logic [BW_ROW-1:0]     asm_q;
  logic [BW_ROW-1:0]     asm_next;
  logic [BW_ROW-1:0]     out_data;
  logic                  out_valid;
  logic                  out_last;
  logic                  req_fire;
  logic                  rsp_fire;
  logic                  row_done;
  logic                  row_fire;

  assign sinst_wready         = (state == ST_IDLE);
  assign sinst_decode_finish  = (state == ST_DECODE);
  assign sinst_execute_finish = (state == ST_DONE);
  assign sinst_busy           = (state != ST_IDLE);

  assign load_tensor_row_wvalid = out_valid;
  assign load_tensor_row_wlast  = out_last;
  assign load_tensor_row_wdata  = out_data;

  // Only a row-completing beat needs the output slot, so only that beat waits on wready
  assign rresp_ready = (state == ST_RUN) &&
                       !((rsp_beat == LAST_BEAT) && out_valid && !load_tensor_row_wready);
  assign req_fire    = rreq_valid && rreq_ready;
  assign rsp_fire    = rresp_valid && rresp_ready;
  assign row_done    = rsp_fire && (rsp_beat == LAST_BEAT);
  assign row_fire    = out_valid && load_tensor_row_wready;

  dca_row_loader_addrgen #(
    .BW_ADDR       (BW_ADDR),
    .BW_DATA       (BW_DATA),
    .BEATS_PER_ROW (BEATS_PER_ROW)
  ) u_addrgen (
    .clk     (clk),
    .rstp    (rstp),
    .clear   (state == ST_DECODE),
    .enable  (state == ST_RUN),
    .allow   (outstanding < MAX_OUT),
    .base    (base_q),
    .stride  (stride_q),
    .num_row (num_row_q),
    .valid   (rreq_valid),
    .ready   (rreq_ready),
    .addr    (rreq_addr)
  );

  always_comb begin
    asm_next = asm_q;
    for (int b = 0; b < BEATS_PER_ROW; b++) begin
      if (rsp_beat == BW_BEAT'(b)) asm_next[b*BW_DATA +: BW_DATA] = rresp_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      state     <= ST_IDLE;
      base_q    <= '0;
      stride_q  <= '0;
      num_row_q <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (sinst_wvalid) begin
            base_q    <= BW_ADDR'(sinst_wdata[BASE_LSB +: BW_INST_FIELD]);
            stride_q  <= BW_ADDR'(sinst_wdata[STRIDE_LSB +: BW_INST_FIELD]);
            num_row_q <= sinst_wdata[NUM_ROW_LSB +: BW_NUM_ROW];
            state     <= ST_DECODE;
          end
        end
        ST_DECODE: state <= (num_row_q == '0) ? ST_DONE : ST_RUN;
        ST_RUN:    if (row_fire && out_last) state <= ST_DONE;
        ST_DONE:   state <= ST_IDLE;
        default:   state <= ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rstp) begin
      outstanding <= '0;
      rsp_beat    <= '0;
      rows_built  <= '0;
      asm_q       <= '0;
      out_data    <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else if (state == ST_DECODE) begin
      outstanding <= '0;
      rsp_beat    <= '0;
      rows_built  <= '0;
      out_valid   <= 1'b0;
      out_last    <= 1'b0;
    end else begin
      if (req_fire && !rsp_fire) outstanding <= outstanding + 1'b1;
      else if (!req_fire && rsp_fire) outstanding <= outstanding - 1'b1;

      if (rsp_fire) begin
        asm_q    <= asm_next;
        rsp_beat <= (rsp_beat == LAST_BEAT) ? '0 : rsp_beat + 1'b1;
      end

      // A completed row refills the output slot in the same cycle it drains
      if (row_done) begin
        out_data   <= asm_next;
        out_valid  <= 1'b1;
        out_last   <= (rows_built == num_row_q - 1'b1);
        rows_built <= rows_built + 1'b1;
      end else if (row_fire) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_dca_matrix_row_loader.sv
// Randomized scoreboard bench for dca_matrix_row_loader with an in-bench memory model.
module tb_dca_matrix_row_loader;
  localparam int BW_ADDR = 32;
  localparam int BW_DATA = 64;
  localparam int BEATS   = 2;
  localparam int MAXO    = 4;
  localparam int BW_ROW  = BW_DATA * BEATS;

  logic                clk = 1'b0;
  logic                rstp = 1'b1;
  logic                sinst_wvalid = 1'b0;
  logic [79:0]         sinst_wdata = '0;
  logic                sinst_wready, sinst_decode_finish, sinst_execute_finish, sinst_busy;
  logic                rreq_valid;
  logic                rreq_ready = 1'b0;
  logic [BW_ADDR-1:0]  rreq_addr;
  logic                rresp_valid = 1'b0;
  logic                rresp_ready;
  logic [BW_DATA-1:0]  rresp_data = '0;
  logic                load_tensor_row_wvalid;
  logic                load_tensor_row_wready = 1'b0;
  logic                load_tensor_row_wlast;
  logic [BW_ROW-1:0]   load_tensor_row_wdata;

  int checks = 0;
  int errors = 0;
  int unsigned cyc = 0;

  int lat = 1;
  int rreq_pct = 100;
  int wready_pct = 100;
  bit wr_block = 1'b0;

  typedef struct {
    logic [31:0] addr;
    int unsigned due;
  } pend_t;
  pend_t pend_q[$];

  logic [31:0]     exp_addr_q[$];
  logic [BW_ROW:0] exp_row_q[$];

  int tb_out = 0;
  int max_out = 0;
  int tb_beat = 0;
  int exec_cnt = 0;
  int saw_drop = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  dca_matrix_row_loader #(
    .BW_ADDR(BW_ADDR), .BW_DATA(BW_DATA), .BEATS_PER_ROW(BEATS), .MAX_OUTSTANDING(MAXO)
  ) dut (
    .clk                    (clk),
    .rstp                   (rstp),
    .sinst_wvalid           (sinst_wvalid),
    .sinst_wdata            (sinst_wdata),
    .sinst_wready           (sinst_wready),
    .sinst_decode_finish    (sinst_decode_finish),
    .sinst_execute_finish   (sinst_execute_finish),
    .sinst_busy             (sinst_busy),
    .rreq_valid             (rreq_valid),
    .rreq_ready             (rreq_ready),
    .rreq_addr              (rreq_addr),
    .rresp_valid            (rresp_valid),
    .rresp_ready            (rresp_ready),
    .rresp_data             (rresp_data),
    .load_tensor_row_wvalid (load_tensor_row_wvalid),
    .load_tensor_row_wready (load_tensor_row_wready),
    .load_tensor_row_wlast  (load_tensor_row_wlast),
    .load_tensor_row_wdata  (load_tensor_row_wdata)
  );

  function automatic logic [63:0] mem_word(input logic [31:0] a);
    return {a ^ 32'hdead_beef, ~a};
  endfunction

  task automatic chk(input string name, input logic [BW_ROW:0] act, input logic [BW_ROW:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Memory model: in-order responses, each due lat cycles after its request
  always @(negedge clk) begin
    rreq_ready = ($urandom_range(1, 100) <= rreq_pct);
    load_tensor_row_wready = !wr_block && ($urandom_range(1, 100) <= wready_pct);
    if (pend_q.size() > 0 && pend_q[0].due <= cyc) begin
      rresp_valid = 1'b1;
      rresp_data  = mem_word(pend_q[0].addr);
    end else begin
      rresp_valid = 1'b0;
      rresp_data  = {$urandom, $urandom};
    end
    #1;
    if (rstp) begin
      pend_q.delete();
    end else begin
      if (rresp_valid && rresp_ready) void'(pend_q.pop_front());
      if (rreq_valid && rreq_ready) pend_q.push_back('{addr: rreq_addr, due: cyc + lat});
    end
  end

  // Monitor: pops expectations whenever the DUT completes a handshake
  bit                prev_req_stall = 1'b0;
  bit                prev_row_stall = 1'b0;
  bit                prev_last_fire = 1'b0;
  logic [31:0]       prev_addr = '0;
  logic [BW_ROW-1:0] prev_wdata = '0;
  logic              prev_wlast = 1'b0;

  always @(negedge clk) begin
    bit run;
    #2;
    if (rstp) begin
      tb_out = 0;
      tb_beat = 0;
      prev_req_stall = 1'b0;
      prev_row_stall = 1'b0;
      prev_last_fire = 1'b0;
    end else begin
      run = sinst_busy && !sinst_decode_finish && !sinst_execute_finish;
      if (rreq_valid) chk("rreq_expected", exp_addr_q.size() != 0, 1);
      if (tb_out >= MAXO) chk("rreq_credit", rreq_valid, 0);
      if (prev_req_stall) chk("rreq_stable", {rreq_valid, rreq_addr}, {1'b1, prev_addr});
      if (prev_row_stall)
        chk("row_stable", {load_tensor_row_wvalid, load_tensor_row_wlast, load_tensor_row_wdata},
            {1'b1, prev_wlast, prev_wdata});
      if (prev_last_fire) chk("finish_latency", sinst_execute_finish, 1);
      if (!load_tensor_row_wvalid) chk("wlast_idle", load_tensor_row_wlast, 0);
      if (sinst_execute_finish) exec_cnt++;

      if (rreq_valid && rreq_ready) begin
        if (exp_addr_q.size() != 0) chk("rreq_addr", rreq_addr, exp_addr_q.pop_front());
        tb_out++;
        if (tb_out > max_out) max_out = tb_out;
      end
      if (rresp_valid && run) begin
        chk("rresp_ready", rresp_ready,
            !((tb_beat == BEATS - 1) && load_tensor_row_wvalid && !load_tensor_row_wready));
        if (!rresp_ready) saw_drop++;
      end
      if (rresp_valid && rresp_ready) begin
        tb_out--;
        tb_beat = (tb_beat + 1) % BEATS;
      end
      if (load_tensor_row_wvalid && load_tensor_row_wready) begin
        chk("row_expected", exp_row_q.size() != 0, 1);
        if (exp_row_q.size() != 0)
          chk("row_data", {load_tensor_row_wlast, load_tensor_row_wdata}, exp_row_q.pop_front());
      end

      prev_req_stall = rreq_valid && !rreq_ready;
      prev_row_stall = load_tensor_row_wvalid && !load_tensor_row_wready;
      prev_last_fire = load_tensor_row_wvalid && load_tensor_row_wready && load_tensor_row_wlast;
      prev_addr  = rreq_addr;
      prev_wdata = load_tensor_row_wdata;
      prev_wlast = load_tensor_row_wlast;
    end
  end

  task automatic chk_reset_vals();
    chk("rst_ctrl", {sinst_wready, sinst_busy, sinst_decode_finish, sinst_execute_finish,
                     rreq_valid, rresp_ready, load_tensor_row_wvalid, load_tensor_row_wlast},
        8'b1000_0000);
    chk("rst_addr", rreq_addr, 0);
    chk("rst_wdata", load_tensor_row_wdata, 0);
  endtask

  // Pushes expectations, issues the instruction, and checks decode-side latencies
  task automatic start_inst(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] num);
    logic [31:0]       a;
    logic [BW_ROW-1:0] row;
    logic              lastb;
    bit                idle;
    for (int r = 0; r < int'(num); r++) begin
      row = '0;
      for (int b = 0; b < BEATS; b++) begin
        a = base + r * stride + b * (BW_DATA / 8);
        exp_addr_q.push_back(a);
        row[b*BW_DATA +: BW_DATA] = mem_word(a);
      end
      lastb = (r == int'(num) - 1);
      exp_row_q.push_back({lastb, row});
    end
    exec_cnt = 0;
    idle = 1'b0;
    for (int i = 0; i < 200 && !idle; i++) begin
      @(negedge clk);
      idle = sinst_wready;
    end
    chk("idle_before_issue", idle, 1);
    sinst_wvalid = 1'b1;
    sinst_wdata  = {num, stride, base};
    @(negedge clk);
    sinst_wvalid = 1'b0;
    sinst_wdata  = '0;
    chk("decode_finish_t1", {sinst_decode_finish, sinst_wready}, 2'b10);
    @(negedge clk);
    if (num == 0) begin
      chk("num0_finish_t2", {sinst_execute_finish, rreq_valid}, 2'b10);
      @(negedge clk);
      chk("num0_wready_t3", {sinst_wready, sinst_execute_finish}, 2'b10);
    end else begin
      chk("first_rreq_t2", rreq_valid, 1);
    end
  endtask

  task automatic wait_done();
    bit done;
    done = 1'b0;
    for (int i = 0; i < 4000 && !done; i++) begin
      @(negedge clk);
      #3;
      done = (exec_cnt > 0);
    end
    chk("finish_seen", done, 1);
    repeat (3) @(negedge clk);
    chk("exec_once", exec_cnt, 1);
    chk("addr_drained", exp_addr_q.size(), 0);
    chk("rows_drained", exp_row_q.size(), 0);
    chk("idle_after", sinst_wready, 1);
    exp_addr_q.delete();
    exp_row_q.delete();
  endtask

  task automatic run_inst(input logic [31:0] base, input logic [31:0] stride, input logic [15:0] num);
    start_inst(base, stride, num);
    wait_done();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    bit hit;
    rstp = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    chk_reset_vals();
    rstp = 1'b0;

    // Basic stream, fast memory
    lat = 1; rreq_pct = 100; wready_pct = 100;
    run_inst(32'h0000_1000, 32'h40, 16'd3);

    // Empty instruction
    run_inst(32'h0000_2000, 32'h10, 16'd0);

    // Address wrap-around
    run_inst(32'hFFFF_FFF8, 32'h8, 16'd2);

    // Slow memory saturates the outstanding window
    lat = 10; max_out = 0;
    run_inst(32'h0000_4000, 32'h100, 16'd4);
    chk("outstanding_peak", max_out, MAXO);

    // Core stalls for 20 cycles mid-stream
    lat = 2; saw_drop = 0;
    fork
      run_inst(32'h0000_8000, 32'h20, 16'd6);
      begin
        repeat (8) @(posedge clk);
        wr_block = 1'b1;
        repeat (20) @(posedge clk);
        wr_block = 1'b0;
      end
    join
    chk("stall_drop_seen", saw_drop > 0, 1);

    // Reset with requests in flight, then a clean instruction
    lat = 10;
    start_inst(32'h0001_0000, 32'h80, 16'd4);
    hit = 1'b0;
    for (int i = 0; i < 100 && !hit; i++) begin
      @(negedge clk);
      if (tb_out == 3) begin
        hit = 1'b1;
        rstp = 1'b1;
        exp_addr_q.delete();
        exp_row_q.delete();
      end
    end
    chk("reached_3_outstanding", hit, 1);
    rstp = 1'b1;
    @(negedge clk);
    #1;
    chk_reset_vals();
    rstp = 1'b0;
    lat = 1;
    run_inst(32'h0002_0000, 32'h18, 16'd2);

    // Random instructions with random memory latency and backpressure
    for (int k = 0; k < 8; k++) begin
      lat        = $urandom_range(1, 6);
      rreq_pct   = $urandom_range(40, 100);
      wready_pct = $urandom_range(40, 100);
      run_inst($urandom, $urandom, 16'($urandom_range(1, 5)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
